// File: rtl/time_set_ctrl.sv
// time_set_ctrl: pushbutton front end for the century clock.
// Synchronises and debounces mode/inc/dec, walks the field-select FSM,
// emits registered up/down adjust pulses with auto-repeat, and generates
// the seconds tick and the blink for the field being set.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_RUN   | clock running, prescaler active, adjust ignored
// ST_SEC   | setting seconds
// ST_MIN   | setting minutes
// ST_HOUR  | setting hours
// ST_DAY   | setting day
// ST_MONTH | setting month
// ST_YEAR  | setting year
module time_set_ctrl #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int TICK_DIV     = 50000000,
    parameter int BLINK_DIV    = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       tick_en,
    output logic       en_s,
    output logic       up_s,
    output logic       down_s,
    output logic       up_m,
    output logic       down_m,
    output logic       up_h,
    output logic       down_h,
    output logic       up_d,
    output logic       down_d,
    output logic       up_mo,
    output logic       down_mo,
    output logic       up_y,
    output logic       down_y,
    output logic [2:0] field,
    output logic       blink
);

    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam int TK_W   = $clog2(TICK_DIV + 1);
    localparam int BL_W   = $clog2(BLINK_DIV + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_RATE - 1);
    localparam logic [TK_W-1:0] TK_LAST  = TK_W'(TICK_DIV - 1);
    localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SEC   = 3'd1,
        ST_MIN   = 3'd2,
        ST_HOUR  = 3'd3,
        ST_DAY   = 3'd4,
        ST_MONTH = 3'd5,
        ST_YEAR  = 3'd6
    } state_t;

    // bit 0 = mode, bit 1 = inc, bit 2 = dec
    logic [2:0]      w_btn_raw;
    logic [2:0]      r_sync1, r_sync2, r_stable, r_stable_d;
    logic [DB_W-1:0] r_db_cnt [3];
    logic [2:0]      w_ev;

    state_t          r_state, w_next_state;
    logic [5:0]      w_fsel, r_up, r_down;
    logic            r_rep_act, r_rep_inc, w_rep_held, w_both;
    logic [RP_W-1:0] r_rep_cnt;

    logic [TK_W-1:0] r_tick_cnt;
    logic            r_en_s;
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_blink;

    assign w_btn_raw  = {btn_dec, btn_inc, btn_mode};
    assign w_ev       = r_stable & ~r_stable_d;
    assign w_both     = r_stable[1] & r_stable[2];
    assign w_rep_held = r_rep_inc ? r_stable[1] : r_stable[2];

    // Two-flop synchronisers, debounce counters and delayed levels for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1    <= w_btn_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next field on a mode press event; YEAR wraps back to RUN.
    always_comb begin
        w_next_state = r_state;
        if (w_ev[0]) begin
            w_next_state = (r_state == ST_YEAR) ? ST_RUN : state_t'(r_state + 3'd1);
        end
    end

    // One-hot pointer to the adjust output pair of the field being set.
    always_comb begin
        w_fsel = '0;
        case (r_state)
            ST_SEC:   w_fsel = 6'b000001;
            ST_MIN:   w_fsel = 6'b000010;
            ST_HOUR:  w_fsel = 6'b000100;
            ST_DAY:   w_fsel = 6'b001000;
            ST_MONTH: w_fsel = 6'b010000;
            ST_YEAR:  w_fsel = 6'b100000;
            default:  w_fsel = '0;
        endcase
    end

    // Field FSM with adjust pulses; a mode press or both buttons held cancels repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_up      <= '0;
            r_down    <= '0;
            r_rep_act <= 1'b0;
            r_rep_inc <= 1'b0;
            r_rep_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_up    <= '0;
            r_down  <= '0;
            if (w_ev[0] || r_state == ST_RUN || w_both) begin
                r_rep_act <= 1'b0;
                r_rep_cnt <= '0;
            end else if (w_ev[1] || w_ev[2]) begin
                r_rep_act <= 1'b1;
                r_rep_inc <= w_ev[1];
                r_rep_cnt <= RP_FIRST;
                if (w_ev[1]) r_up <= w_fsel;
                else         r_down <= w_fsel;
            end else if (r_rep_act) begin
                if (!w_rep_held) begin
                    r_rep_act <= 1'b0;
                    r_rep_cnt <= '0;
                end else if (r_rep_cnt == '0) begin
                    r_rep_cnt <= RP_NEXT;
                    if (r_rep_inc) r_up <= w_fsel;
                    else           r_down <= w_fsel;
                end else begin
                    r_rep_cnt <= r_rep_cnt - 1'b1;
                end
            end
        end
    end

    // Seconds prescaler: runs only while staying in RUN, cleared otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_en_s     <= 1'b0;
        end else begin
            r_en_s <= 1'b0;
            if (r_state != ST_RUN || w_next_state != ST_RUN) begin
                r_tick_cnt <= '0;
            end else if (tick_en) begin
                if (r_tick_cnt == TK_LAST) begin
                    r_tick_cnt <= '0;
                    r_en_s     <= 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    // Blink toggles every BLINK_DIV cycles in a set state, restarting on entry from RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_next_state == ST_RUN || r_state == ST_RUN) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BL_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign en_s    = r_en_s;
    assign field   = r_state;
    assign blink   = r_blink;
    assign up_s    = r_up[0];
    assign down_s  = r_down[0];
    assign up_m    = r_up[1];
    assign down_m  = r_down[1];
    assign up_h    = r_up[2];
    assign down_h  = r_down[2];
    assign up_d    = r_up[3];
    assign down_d  = r_down[3];
    assign up_mo   = r_up[4];
    assign down_mo = r_down[4];
    assign up_y    = r_up[5];
    assign down_y  = r_down[5];

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed vector table plus hand sequences for time_set_ctrl.
module tb_time_set_ctrl;

    logic        clk = 1'b0;
    logic        rst, btn_mode, btn_inc, btn_dec, tick_en;
    logic        en_s, blink;
    logic        up_s, down_s, up_m, down_m, up_h, down_h;
    logic        up_d, down_d, up_mo, down_mo, up_y, down_y;
    logic [2:0]  field;
    logic [11:0] adj;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mode;
        logic        inc;
        logic        dec;
        int          cyc;
        int          fld;
        int          ens;
        int          nadj;
        logic [11:0] mask;
        int          blk;
    } vec_t;

    vec_t vecs[19];

    time_set_ctrl #(
        .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_RATE(5),
        .TICK_DIV(10), .BLINK_DIV(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .tick_en(tick_en), .en_s(en_s),
        .up_s(up_s), .down_s(down_s), .up_m(up_m), .down_m(down_m),
        .up_h(up_h), .down_h(down_h), .up_d(up_d), .down_d(down_d),
        .up_mo(up_mo), .down_mo(down_mo), .up_y(up_y), .down_y(down_y),
        .field(field), .blink(blink)
    );

    assign adj = {down_y, up_y, down_mo, up_mo, down_d, up_d,
                  down_h, up_h, down_m, up_m, down_s, up_s};

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("adj_at_most_one", ($countones(adj) <= 1) ? 1 : 0, 1);
    endtask

    task automatic apply_vec(input int i);
        int ne = 0;
        int na = 0;
        logic [11:0] m = '0;
        btn_mode = vecs[i].mode;
        btn_inc  = vecs[i].inc;
        btn_dec  = vecs[i].dec;
        for (int k = 0; k < vecs[i].cyc; k++) begin
            step();
            ne += int'(en_s);
            na += $countones(adj);
            m  |= adj;
        end
        check($sformatf("v%0d_field", i), int'(field), vecs[i].fld);
        check($sformatf("v%0d_en_s_count", i), ne, vecs[i].ens);
        check($sformatf("v%0d_adj_count", i), na, vecs[i].nadj);
        check($sformatf("v%0d_adj_mask", i), int'(m), int'(vecs[i].mask));
        if (vecs[i].blk >= 0) check($sformatf("v%0d_blink", i), int'(blink), vecs[i].blk);
    endtask

    task automatic press_mode(input int exp_field);
        btn_mode = 1'b1;
        for (int k = 0; k < 8; k++) step();
        btn_mode = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check($sformatf("press_to_field%0d", exp_field), int'(field), exp_field);
    endtask

    initial begin
        int tq[$];
        int exp_t[6];
        int other;
        int first;
        int k;
        int na;

        // mode inc dec cyc | field en_s adj_count adj_mask blink(-1 = skip)
        vecs[0]  = '{1'b1, 1'b0, 1'b0,  3, 0, 0, 0, 12'h000,  0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 10, 0, 1, 0, 12'h000,  0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0,  6, 0, 0, 0, 12'h000,  0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,  1, 1, 0, 0, 12'h000,  0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0,  5, 1, 0, 0, 12'h000,  0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 10, 1, 0, 0, 12'h000,  1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0,  8, 2, 0, 0, 12'h000, -1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 10, 2, 0, 0, 12'h000, -1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0,  6, 2, 0, 0, 12'h000, -1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0,  1, 2, 0, 1, 12'h004, -1};
        vecs[10] = '{1'b0, 1'b1, 1'b0,  3, 2, 0, 0, 12'h000, -1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 30, 2, 0, 0, 12'h000, -1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 20, 1, 0, 0, 12'h000, -1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 40, 1, 0, 0, 12'h000, -1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 10, 1, 0, 0, 12'h000, -1};
        vecs[15] = '{1'b0, 1'b1, 1'b0,  6, 1, 0, 0, 12'h000, -1};
        vecs[16] = '{1'b0, 1'b1, 1'b0,  1, 1, 0, 1, 12'h001, -1};
        vecs[17] = '{1'b0, 1'b1, 1'b0,  3, 1, 0, 0, 12'h000, -1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 30, 1, 0, 0, 12'h000, -1};
        exp_t = '{7, 27, 32, 37, 42, 47};

        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; tick_en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("reset_field", int'(field), 0);
        check("reset_en_s", int'(en_s), 0);
        check("reset_adj", int'(adj), 0);
        check("reset_blink", int'(blink), 0);
        rst = 1'b0;

        // free-running seconds tick
        for (int c = 1; c <= 30; c++) begin
            step();
            check($sformatf("t1_en_s_c%0d", c), int'(en_s), (c % 10 == 0) ? 1 : 0);
        end
        check("t1_field", int'(field), 0);
        check("t1_blink", int'(blink), 0);

        // short mode glitch, real mode press, blink, field 2, single up_m
        for (int i = 0; i <= 11; i++) apply_vec(i);

        // dec auto-repeat on the hour field
        press_mode(3);
        other = 0;
        btn_dec = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            if (c == 45) btn_dec = 1'b0;
            step();
            if (down_h) tq.push_back(c);
            if ((adj & ~12'h020) != 12'h000) other++;
            if (en_s) other++;
        end
        check("t4_pulse_count", tq.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t4_pulse%0d_cycle", i), (i < tq.size()) ? tq[i] : -1, exp_t[i]);
        check("t4_stray_outputs", other, 0);

        // simultaneous inc/dec on the seconds field
        press_mode(4); press_mode(5); press_mode(6); press_mode(0); press_mode(1);
        for (int i = 12; i <= 18; i++) apply_vec(i);

        // wrap back to RUN and restart the prescaler
        press_mode(2); press_mode(3); press_mode(4); press_mode(5); press_mode(6);
        btn_mode = 1'b1;
        k = 0;
        while (field != 3'd0 && k < 20) begin
            step();
            k++;
        end
        check("t5_wrap_latency", k, 7);
        check("t5_blink_in_run", int'(blink), 0);
        btn_mode = 1'b0;
        first = -1;
        for (int m = 1; m <= 15; m++) begin
            step();
            if (en_s && first < 0) first = m;
        end
        check("t5_first_en_s", first, 10);

        // reset during dec auto-repeat
        press_mode(1); press_mode(2); press_mode(3);
        btn_dec = 1'b1;
        na = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            na += int'(down_h);
        end
        check("t6_pre_reset_pulses", na, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_reset_field", int'(field), 0);
        check("t6_reset_adj", int'(adj), 0);
        check("t6_reset_en_s", int'(en_s), 0);
        check("t6_reset_blink", int'(blink), 0);
        na = 0;
        first = -1;
        for (int m = 1; m <= 40; m++) begin
            step();
            na += $countones(adj);
            if (en_s && first < 0) first = m;
        end
        check("t6_post_reset_adj", na, 0);
        check("t6_post_reset_field", int'(field), 0);
        check("t6_first_en_s", first, 10);
        btn_dec = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Front-end controller that drives the century clock's time-setting inputs.
- Conditions three raw pushbuttons (mode, inc, dec): 2-FF synchronise, debounce, edge-detect.
- Runs a field-select FSM and emits the single-cycle up_*/down_* pulses the clock counters consume, with auto-repeat on held buttons.
- Generates the seconds enable en_s from a prescaler. The prescaler is frozen while a field is being set.

Parameters:
DEBOUNCE_CYC, 500000, consecutive stable synced cycles required to accept a button level change
REPEAT_DELAY, 25000000, cycles from first pulse to first auto-repeat pulse
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses
TICK_DIV, 50000000, clk cycles per en_s pulse
BLINK_DIV, 12500000, cycles per blink toggle

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_inc  in  1  raw increment button, asynchronous, active-high
btn_dec  in  1  raw decrement button, asynchronous, active-high
tick_en  in  1  run enable for the prescaler
en_s  out  1  one-cycle seconds tick
up_s, down_s, up_m, down_m, up_h, down_h, up_d, down_d, up_mo, down_mo, up_y, down_y  out  1 each  one-cycle adjust pulses
field  out  3  0=RUN, 1=SEC, 2=MIN, 3=HOUR, 4=DAY, 5=MONTH, 6=YEAR
blink  out  1  display blink for the selected field

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: on any clk edge with rst=1, every output is 0; FSM=RUN; all counters=0; synchronisers=0; debounced levels=0. Reset mid-operation aborts any repeat. No pulse is emitted in the reset cycle.
- Synchronise: each button passes through 2 flops.
- Debounce, per button: a counter increments while the synced level differs from the stable level and clears when they match. When the counter reaches DEBOUNCE_CYC, the stable level flips and the counter clears.
- Press event: one cycle on a stable 0->1 transition.
- FSM states: RUN -> SEC -> MIN -> HOUR -> DAY -> MONTH -> YEAR -> RUN.
  - Each mode press event advances one state. field is registered and updates on the cycle after the event.
- In RUN: inc/dec events are ignored and no up/down pulses are emitted.
- In a SET state: an inc (dec) press event produces up_x (down_x) for exactly 1 cycle on the following cycle.
  - Total latency from raw rising edge to pulse is DEBOUNCE_CYC+3 cycles.
- Auto-repeat: while the stable inc (or dec) level stays 1, a further pulse fires REPEAT_DELAY cycles after the initial pulse, then every REPEAT_RATE cycles. Release stops repeating immediately.
- Simultaneous inc and dec:
  - Both stable levels 1 -> all adjust pulses suppressed and the repeat counter cleared.
  - Press events on the same cycle -> no pulse.
  - Pulses resume only after a fresh press event once at most one button is held.
- Mode press while inc/dec is held: the field advances, repeat is cancelled, and no pulse goes to the new field until a fresh inc/dec press event.
- Exclusivity: at most one of the 12 adjust outputs is high in any cycle. All adjust outputs are registered.
- Prescaler: counts 0..TICK_DIV-1 only when FSM=RUN and tick_en=1.
  - en_s=1 on the cycle the count equals TICK_DIV-1, then the count wraps to 0.
  - tick_en=0 holds the count.
  - In any SET state the count is cleared to 0 and en_s=0.
  - On return to RUN, the first en_s occurs TICK_DIV cycles later.
- Blink: toggles every BLINK_DIV cycles in SET states. blink=0 and its counter=0 in RUN.
- Buttons held through reset register as press events after reset: a held mode button enters SEC; a held inc/dec in RUN is ignored.

Test Plan:
Bench overrides: DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5, TICK_DIV=10, BLINK_DIV=8.
1. Release rst, tick_en=1 for 30 cycles -> en_s high on cycles 10, 20 and 30 after release only; field=0; blink=0; all adjust outputs 0.
2. btn_mode high for 3 cycles then low -> no field change. btn_mode high for 12 cycles -> field=1 exactly 7 cycles after the raw edge, and en_s stays 0 from then on.
3. Two mode presses (field=2), then btn_inc held for 10 cycles -> exactly one up_m pulse, 7 cycles after the inc edge; no other adjust output ever high.
4. field=3, btn_dec held 40 cycles after its pulse at t0 -> down_h at t0, t0+20, t0+25, t0+30, t0+35, t0+40; pulses stop within 1 cycle of the debounced release.
5. field=1, inc and dec raised on the same cycle and held -> zero pulses; release dec only -> no pulse until inc is re-pressed. Then 6 mode presses -> field wraps 1->...->6->0, blink=0, and the first en_s arrives 10 cycles after entering RUN.
6. rst asserted for 1 cycle during dec auto-repeat with dec still held -> next cycle field=0 and all outputs 0; no down_* pulse after reset; en_s resumes at 10 cycles.
